// File: rtl/sound_pkg.sv
// Shared sound constants for the 12 MHz board: clock rate and note half-periods
// (in clock cycles) ready to be loaded into a tone channel.
package sound_pkg;

    localparam int CLOCK_FREQUENCY = 12000000;
    localparam int MAX_CHANNELS    = 8;

    localparam int NOTE_C4_HALF = 22933;
    localparam int NOTE_E4_HALF = 18202;
    localparam int NOTE_G4_HALF = 15306;

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone voice: shadow half-period register, cycle counter and
// toggle flop. A zero half-period or a low enable keeps the voice silent.
module tone_channel
    import sound_pkg::*;
#(
    parameter int period_width = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [period_width-1:0] half_period,
    output logic                    tone
);

    localparam logic [period_width-1:0] ONE = period_width'(1);

    logic [period_width-1:0] shadow;
    logic [period_width-1:0] counter;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            counter <= '0;
            tone    <= 1'b0;
        end else if (load) begin
            // Restart on load so every voice comes back phase-aligned.
            shadow  <= half_period;
            counter <= '0;
            tone    <= 1'b0;
        end else if (!enable || shadow == '0) begin
            counter <= '0;
            tone    <= 1'b0;
        end else if (counter == shadow - ONE) begin
            counter <= '0;
            tone    <= ~tone;
        end else begin
            counter <= counter + ONE;
        end
    end

endmodule

// File: rtl/tone_pwm_mixer.sv
// Multi-channel square-wave tone generator; active voices are counted, scaled by
// volume once per PWM period and emitted as a single-bit PWM stream.
module tone_pwm_mixer
    import sound_pkg::*;
#(
    parameter int n_channels   = 3,
    parameter int period_width = 16,
    parameter int pwm_width    = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [n_channels-1:0]              enable,
    input  logic [n_channels*period_width-1:0] half_period,
    input  logic                               load,
    input  logic [pwm_width-1:0]               volume,
    output logic [n_channels-1:0]              tone_out,
    output logic                               pwm_out,
    output logic                               sample_strobe
);

    localparam int sum_width  = $clog2(n_channels + 1);
    localparam int prod_width = pwm_width + sum_width;

    logic [sum_width-1:0]  tone_count;
    logic [prod_width-1:0] level_next;
    logic [prod_width-1:0] pwm_counter;
    logic [prod_width-1:0] level_reg;

    for (genvar i = 0; i < n_channels; i++) begin : g_ch
        tone_channel #(
            .period_width(period_width)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .enable     (enable[i]),
            .load       (load),
            .half_period(half_period[i*period_width +: period_width]),
            .tone       (tone_out[i])
        );
    end

    always_comb begin
        tone_count = '0;
        for (int i = 0; i < n_channels; i++) begin
            tone_count = tone_count + sum_width'(tone_out[i]);
        end
    end

    // Both operands widened to the product width; n_channels*(2^pwm_width-1) always fits.
    assign level_next = {{pwm_width{1'b0}}, tone_count} * {{sum_width{1'b0}}, volume};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_counter   <= '0;
            level_reg     <= '0;
            sample_strobe <= 1'b0;
            pwm_out       <= 1'b0;
        end else begin
            pwm_counter   <= pwm_counter + prod_width'(1);
            sample_strobe <= &pwm_counter;
            // Level only changes at the wrap so each PWM period has one duty.
            if (&pwm_counter) begin
                level_reg <= level_next;
            end
            pwm_out <= (pwm_counter < level_reg);
        end
    end

endmodule

// File: tb/tb_tone_pwm_mixer.sv
// Directed bench for tone_pwm_mixer: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for tone timing and PWM duty.
module tb_tone_pwm_mixer;

    localparam int N      = 3;
    localparam int PW     = 16;
    localparam int VW     = 8;
    localparam int PERIOD = 1024;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    enable = '0;
    logic [N*PW-1:0] half_period = '0;
    logic            load = 1'b0;
    logic [VW-1:0]   volume = '0;
    logic [N-1:0]    tone_out;
    logic            pwm_out;
    logic            sample_strobe;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    tone_pwm_mixer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .half_period  (half_period),
        .load         (load),
        .volume       (volume),
        .tone_out     (tone_out),
        .pwm_out      (pwm_out),
        .sample_strobe(sample_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a voice's tone is the parity of (enabled edges since restart) / h.
    int m_h[N];
    int m_run[N];
    int m_k, m_level;
    bit m_pwm, m_strobe;

    function automatic bit m_tone(input int i);
        return (m_h[i] > 0) && (((m_run[i] / m_h[i]) % 2) == 1);
    endfunction

    function automatic int m_pop();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(m_tone(i));
        return s;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_h[i]   <= 0;
                m_run[i] <= 0;
            end
            m_k <= 0; m_level <= 0; m_pwm <= 1'b0; m_strobe <= 1'b0;
        end else begin
            if (m_k == PERIOD - 1) m_level <= m_pop() * int'(volume);
            m_strobe <= (m_k == PERIOD - 1);
            m_pwm    <= (m_k < m_level);
            m_k      <= (m_k + 1) % PERIOD;
            for (int i = 0; i < N; i++) begin
                if (load) begin
                    m_h[i]   <= int'(half_period[i*PW +: PW]);
                    m_run[i] <= 0;
                end else if (!enable[i] || m_h[i] == 0) m_run[i] <= 0;
                else m_run[i] <= m_run[i] + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (!done) begin
            for (int i = 0; i < N; i++) check($sformatf("tone_out[%0d]", i), int'(tone_out[i]), int'(m_tone(i)));
            check("pwm_out", int'(pwm_out), int'(m_pwm));
            check("sample_strobe", int'(sample_strobe), int'(m_strobe));
        end
    end

    // Caller sits at a negedge; load is taken on the following posedge.
    task automatic do_load(input logic [N*PW-1:0] hp);
        half_period = hp;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic cycles_until_tone(input int ch, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tone_out[ch] && n < limit);
    endtask

    // Find a strobe whose sampled tones equal want, then count pwm_out highs over the next period.
    task automatic period_highs(input logic [N-1:0] want, input string name, input int exp);
        logic [N-1:0] prev;
        bit ok = 1'b0;
        int highs = 0;
        prev = tone_out;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(negedge clock);
            if (sample_strobe && prev == want) ok = 1'b1;
            else prev = tone_out;
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
        else begin
            repeat (PERIOD) begin
                @(negedge clock);
                highs += int'(pwm_out);
            end
            check(name, highs, exp);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("reset_tone", int'(tone_out), 0);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_strobe", int'(sample_strobe), 0);
        reset_n = 1'b1;

        // 1: idle, silent, strobe every 1024 cycles
        n = 0;
        do begin @(negedge clock); n++; end while (!sample_strobe && n < 2000);
        check("first_strobe_cycle", n, 1024);
        n = 0;
        do begin @(negedge clock); n++; end while (!sample_strobe && n < 2000);
        check("strobe_interval", n, 1024);
        repeat (2952) @(negedge clock);
        check("idle_tone", int'(tone_out), 0);
        check("idle_pwm", int'(pwm_out), 0);

        // 2: ch0 h=4
        do_load({16'd0, 16'd0, 16'd4});
        enable = 3'b001;
        cycles_until_tone(0, 50, n);
        check("h4_first_rise", n, 4);
        n = 0;
        do begin @(negedge clock); n++; end while (tone_out[0] && n < 50);
        check("h4_high_len", n, 4);
        cycles_until_tone(0, 50, n);
        check("h4_low_len", n, 4);
        check("h4_other_ch", int'(tone_out[2:1]), 0);

        // 5: mid-tone reload, then reload on terminal count
        do_load({16'd0, 16'd0, 16'd6});
        repeat (9) @(negedge clock);
        check("pre_reload_tone", int'(tone_out[0]), 1);
        do_load({16'd0, 16'd0, 16'd6});
        check("reload_clears", int'(tone_out[0]), 0);
        cycles_until_tone(0, 50, n);
        check("reload_rise", n, 6);
        do_load({16'd0, 16'd0, 16'd6});
        repeat (5) @(negedge clock);
        check("pre_terminal_tone", int'(tone_out[0]), 0);
        do_load({16'd0, 16'd0, 16'd6});
        check("terminal_load_wins", int'(tone_out[0]), 0);
        cycles_until_tone(0, 50, n);
        check("terminal_reload_rise", n, 6);

        // 3: ch0 h=2048, volume 255
        volume = 8'd255;
        do_load({16'd0, 16'd0, 16'd2048});
        period_highs(3'b001, "duty_one_ch", 255);
        period_highs(3'b000, "duty_silent", 0);

        // 4: all channels h=8192, volume 200 then 0
        volume = 8'd200;
        enable = 3'b111;
        do_load({16'd8192, 16'd8192, 16'd8192});
        period_highs(3'b111, "duty_three_ch", 600);
        volume = 8'd0;
        period_highs(3'b111, "duty_vol0", 0);

        // 6: async reset pulse mid-tone
        volume = 8'd200;
        period_highs(3'b111, "duty_before_reset", 600);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_tone", int'(tone_out), 0);
        check("async_pwm", int'(pwm_out), 0);
        check("async_strobe", int'(sample_strobe), 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (300) @(negedge clock);
        check("post_reset_silent", int'(tone_out), 0);
        do_load({16'd0, 16'd0, 16'd3});
        cycles_until_tone(0, 50, n);
        check("post_reset_rise", n, 3);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
